// File: rtl/state_uart_tx.sv
// Serial output stage of the atomic-clock FSM chain.
// Sends one announcement code per 8N1-style UART frame, LSB first.
module state_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ann_valid,
  input  logic [DATA_BITS-1:0] ann_data,
  output logic                 ann_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS + STOP_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 baud_tc;
  logic                 take;

  assign ann_ready = (state_q == IDLE);
  assign take      = ann_valid && ann_ready;
  assign baud_tc   = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign tx        = tx_q;
  assign busy      = busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_tc ? '0 : baud_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        if (take) begin
          state_d = START;
          shift_d = ann_data;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        // idx_q counts stop bits so the baud counter stays one bit-time wide
        if (baud_tc) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line changes with state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_state_uart_tx.sv
// Bench for state_uart_tx: frames are predicted from the line format
// (start, LSB-first data, stop) and compared cycle by cycle.
module tb_state_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       v1, v2;
  logic [7:0] d1, d2;
  logic       rdy1, rdy2;
  logic       tx1, tx2;
  logic       busy1, busy2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  state_uart_tx #(
    .CLKS_PER_BIT(4),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ann_valid(v1),
    .ann_data(d1),
    .ann_ready(rdy1),
    .tx(tx1),
    .busy(busy1)
  );

  state_uart_tx #(
    .CLKS_PER_BIT(2),
    .DATA_BITS(8),
    .STOP_BITS(2)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .ann_valid(v2),
    .ann_data(d2),
    .ann_ready(rdy2),
    .tx(tx2),
    .busy(busy2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic line(input int sel);
    return sel != 0 ? tx2 : tx1;
  endfunction

  function automatic logic bsy(input int sel);
    return sel != 0 ? busy2 : busy1;
  endfunction

  function automatic logic rdy(input int sel);
    return sel != 0 ? rdy2 : rdy1;
  endfunction

  // expected line level k cycles after the accepting edge
  function automatic logic ref_level(input logic [7:0] d,
                                     input int cpb, input int k);
    int slot;
    slot = k / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic start_frame(input int sel, input logic [7:0] d);
    @(negedge clk);
    check("ready_before", rdy(sel), 1);
    if (sel != 0) begin v2 = 1'b1; d2 = d; end
    else begin v1 = 1'b1; d1 = d; end
    @(posedge clk);
    #1;
    if (sel != 0) begin v2 = 1'b0; d2 = 8'($urandom); end
    else begin v1 = 1'b0; d1 = 8'($urandom); end
  endtask

  // poke >= 0: raise a foreign request with 8'h3C during that cycle
  task automatic check_frame(input int sel, input logic [7:0] d,
                             input int poke);
    int cpb, f;
    logic [7:0] rx;
    cpb = sel != 0 ? 2 : 4;
    f = (1 + 8 + (sel != 0 ? 2 : 1)) * cpb;
    rx = '0;
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      check("tx_bit", line(sel), ref_level(d, cpb, k));
      check("busy_in_frame", bsy(sel), 1);
      if (k >= cpb && k < 9 * cpb && (k % cpb) == cpb / 2)
        rx[k / cpb - 1] = line(sel);
      if (sel == 0 && k == poke) begin
        v1 = 1'b1;
        d1 = 8'h3C;
      end else if (sel == 0 && poke >= 0 && k == poke + 1) begin
        v1 = 1'b0;
        d1 = 8'($urandom);
      end
    end
    check("rx_byte", rx, d);
    @(negedge clk);
    check("ready_after", rdy(sel), 1);
    check("busy_after", bsy(sel), 0);
    check("tx_idle_after", line(sel), 1);
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b1; d1 = 8'hA5;
    v2 = 1'b0; d2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    check("rst_tx", tx1, 1);
    check("rst_busy", busy1, 0);
    check("rst_ready", rdy1, 1);
    repeat (6) begin
      @(negedge clk);
      check("rst_no_frame", tx1, 1);
    end

    start_frame(0, 8'hA5);
    check_frame(0, 8'hA5, -1);

    @(negedge clk);
    v1 = 1'b1; d1 = 8'h01;
    @(posedge clk);
    #1 d1 = 8'h80;
    check_frame(0, 8'h01, -1);
    @(posedge clk);
    #1 v1 = 1'b0;
    check_frame(0, 8'h80, -1);

    start_frame(0, 8'h96);
    check_frame(0, 8'h96, 13);
    repeat (10) begin
      @(negedge clk);
      check("no_second_frame", tx1, 1);
      check("no_second_busy", busy1, 0);
    end

    start_frame(0, 8'hFF);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("abort_pre", tx1, ref_level(8'hFF, 4, k));
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx", tx1, 1);
    check("abort_busy", busy1, 0);
    check("abort_ready", rdy1, 1);
    start_frame(0, 8'h00);
    check_frame(0, 8'h00, -1);

    start_frame(1, 8'h55);
    check_frame(1, 8'h55, -1);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(i % 2, d);
      check_frame(i % 2, d, (i % 2 == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
